// File: rtl/instr_encode_loader.sv
// Encodes one symbolic instruction per handshake into a 9-bit word and writes it to consecutive ROM slots.
// Handshake-to-write latency 1 cycle, one word per 2 cycles; in_ready drops while the word is being written.
module instr_encode_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_class,
    input  logic [2:0]        alu_op,
    input  logic [2:0]        reg_a,
    input  logic [2:0]        reg_b,
    input  logic [7:0]        imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [8:0]        wr_data,
    output logic [ADDR_W:0]   prog_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WRITE  = 3'd2,
        S_FINISH = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [2:0] OP_R      = 3'd0;
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_LOADR  = 3'd3;
    localparam logic [2:0] OP_LCONST = 3'd4;
    localparam logic [2:0] OP_MOVE   = 3'd5;
    localparam logic [2:0] OP_DONE   = 3'd6;

    localparam logic [1:0] EC_ILLEGAL  = 2'd0;
    localparam logic [1:0] EC_RANGE    = 2'd1;
    localparam logic [1:0] EC_RESERVED = 2'd2;
    localparam logic [1:0] EC_FULL     = 2'd3;

    localparam logic [8:0]        DONE_WORD = 9'h0FF;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t      state, state_nxt;
    logic [8:0]  enc_word;
    logic        fld_err;
    logic [1:0]  fld_code;
    logic        full;
    logic        handshake;

    assign full      = (wr_addr == LAST_ADDR);
    // start outranks a coincident handshake, so the fields are simply not taken
    assign handshake = (state == S_ACCEPT) && in_valid && !start;

    // Encoder and legality checker
    always_comb begin
        enc_word = DONE_WORD;
        fld_err  = 1'b0;
        fld_code = EC_ILLEGAL;
        case (op_class)
            OP_R: begin
                enc_word = {1'b0, alu_op, reg_a[1:0], reg_b};
                if (reg_a > 3'd3) begin
                    fld_err  = 1'b1;
                    fld_code = EC_RANGE;
                end else if ({1'b0, alu_op, reg_a[1:0], reg_b} == DONE_WORD) begin
                    fld_err  = 1'b1;
                    fld_code = EC_RESERVED;
                end
            end
            OP_BRANCH: begin
                enc_word = {3'b100, imm[5:0]};
                if (imm > 8'd63) begin
                    fld_err  = 1'b1;
                    fld_code = EC_RANGE;
                end
            end
            OP_STORE:  enc_word = {3'b101, reg_a, 3'b000};
            OP_LOADR:  enc_word = {3'b110, reg_a, 2'b00, 1'b0};
            OP_LCONST: begin
                enc_word = {3'b110, imm[4:0], 1'b1};
                if (imm > 8'd31) begin
                    fld_err  = 1'b1;
                    fld_code = EC_RANGE;
                end
            end
            OP_MOVE:   enc_word = {3'b111, reg_a, reg_b};
            OP_DONE:   enc_word = DONE_WORD;
            default: begin
                fld_err  = 1'b1;
                fld_code = EC_ILLEGAL;
            end
        endcase
        // The last slot is reserved for DONE so a program is always terminated
        if (full && op_class != OP_DONE) begin
            fld_err  = 1'b1;
            fld_code = EC_FULL;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_ACCEPT;
        end else begin
            case (state)
                S_IDLE:   state_nxt = S_IDLE;
                S_ACCEPT: begin
                    if (handshake) begin
                        state_nxt = fld_err ? S_ERROR : S_WRITE;
                    end
                end
                S_WRITE:  state_nxt = (wr_data == DONE_WORD) ? S_FINISH : S_ACCEPT;
                S_FINISH: state_nxt = S_FINISH;
                S_ERROR:  state_nxt = S_ERROR;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_ACCEPT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                wr_en = !start;
                busy  = 1'b1;
            end
            S_FINISH: done = 1'b1;
            S_ERROR:  err  = 1'b1;
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Datapath: address, length, captured word and error code
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_addr  <= '0;
            wr_data  <= '0;
            prog_len <= '0;
            err_code <= '0;
        end else if (start) begin
            wr_addr  <= '0;
            prog_len <= '0;
            err_code <= '0;
        end else begin
            if (handshake && !fld_err) begin
                wr_data <= enc_word;
            end
            if (handshake && fld_err) begin
                err_code <= fld_code;
            end
            if (state == S_WRITE) begin
                prog_len <= prog_len + 1'b1;
                if (wr_data != DONE_WORD) begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: a full-size instance and a 4-deep instance share the stimulus.
module tb_instr_encode_loader;

    logic       Clk;
    logic       Reset;
    logic       start;
    logic       in_valid;
    logic [2:0] op_class;
    logic [2:0] alu_op;
    logic [2:0] reg_a;
    logic [2:0] reg_b;
    logic [7:0] imm;

    logic       in_ready, wr_en, busy, done, err;
    logic [7:0] wr_addr;
    logic [8:0] wr_data;
    logic [8:0] prog_len;
    logic [1:0] err_code;

    logic       s_in_ready, s_wr_en, s_busy, s_done, s_err;
    logic [1:0] s_wr_addr;
    logic [8:0] s_wr_data;
    logic [2:0] s_prog_len;
    logic [1:0] s_err_code;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int wc;

    instr_encode_loader #(.ADDR_W(8), .DEPTH(256)) u_dut (
        .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .op_class(op_class), .alu_op(alu_op), .reg_a(reg_a), .reg_b(reg_b), .imm(imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .prog_len(prog_len),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    instr_encode_loader #(.ADDR_W(2), .DEPTH(4)) u_small (
        .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .op_class(op_class), .alu_op(alu_op), .reg_a(reg_a), .reg_b(reg_b), .imm(imm),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .prog_len(s_prog_len),
        .busy(s_busy), .done(s_done), .err(s_err), .err_code(s_err_code)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (wr_en === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one field set for one cycle; afterwards the DUT sits in the cycle after the handshake
    task automatic hs(input logic [2:0] op, input logic [2:0] alu, input logic [2:0] a,
                      input logic [2:0] b, input logic [7:0] im);
        op_class = op; alu_op = alu; reg_a = a; reg_b = b; imm = im;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op_class = 3'd0; alu_op = 3'd0; reg_a = 3'd0; reg_b = 3'd0; imm = 8'd0;
    endtask

    task automatic send_chk(input string tag, input logic [2:0] op, input logic [2:0] alu,
                            input logic [2:0] a, input logic [2:0] b, input logic [7:0] im,
                            input logic [7:0] exp_addr, input logic [8:0] exp_data);
        hs(op, alu, a, b, im);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd1);
        chk({tag, "_addr"}, 32'(wr_addr), 32'(exp_addr));
        chk({tag, "_data"}, 32'(wr_data), 32'(exp_data));
        chk({tag, "_rdy_low"}, 32'(in_ready), 32'd0);
        tick();
        chk({tag, "_wr_en_1cyc"}, 32'(wr_en), 32'd0);
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        op_class = 3'd0; alu_op = 3'd0; reg_a = 3'd0; reg_b = 3'd0; imm = 8'd0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_prog_len", 32'(prog_len), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        tick();
        Reset = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // 1: R then DONE
        do_start();
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        send_chk("t1_r", 3'd0, 3'd2, 3'd1, 3'd5, 8'd0, 8'd0, 9'h04D);
        send_chk("t1_done", 3'd6, 3'd0, 3'd0, 3'd0, 8'd0, 8'd1, 9'h0FF);
        chk("t1_done_flag", 32'(done), 32'd1);
        chk("t1_prog_len", 32'(prog_len), 32'd2);
        chk("t1_addr_hold", 32'(wr_addr), 32'd1);
        chk("t1_busy_low", 32'(busy), 32'd0);

        // 2: remaining encodings
        do_start();
        chk("t2_done_clr", 32'(done), 32'd0);
        send_chk("t2_branch", 3'd1, 3'd0, 3'd0, 3'd0, 8'd37, 8'd0, 9'h125);
        send_chk("t2_lconst", 3'd4, 3'd0, 3'd0, 3'd0, 8'd19, 8'd1, 9'h1A7);
        send_chk("t2_move", 3'd5, 3'd0, 3'd6, 3'd3, 8'd0, 8'd2, 9'h1F3);
        send_chk("t2_store", 3'd2, 3'd0, 3'd4, 3'd0, 8'd0, 8'd3, 9'h160);
        send_chk("t2_loadreg", 3'd3, 3'd0, 3'd2, 3'd0, 8'd0, 8'd4, 9'h190);
        chk("t2_prog_len", 32'(prog_len), 32'd5);

        // 3: errors
        wc = wr_cnt;
        hs(3'd1, 3'd0, 3'd0, 3'd0, 8'd64);
        chk("t3_br_err", 32'(err), 32'd1);
        chk("t3_br_code", 32'(err_code), 32'd1);
        chk("t3_br_no_wr", 32'(wr_en), 32'd0);
        chk("t3_br_addr", 32'(wr_addr), 32'd5);
        tick();
        chk("t3_br_wr_cnt", 32'(wr_cnt - wc), 32'd0);
        do_start();
        hs(3'd0, 3'd7, 3'd3, 3'd7, 8'd0);
        chk("t3_rsv_err", 32'(err), 32'd1);
        chk("t3_rsv_code", 32'(err_code), 32'd2);
        chk("t3_rsv_no_wr", 32'(wr_en), 32'd0);
        do_start();
        chk("t3_err_clr", 32'(err), 32'd0);
        chk("t3_code_clr", 32'(err_code), 32'd0);
        hs(3'd0, 3'd0, 3'd4, 3'd0, 8'd0);
        chk("t3_rega_code", 32'(err_code), 32'd1);
        do_start();
        hs(3'd7, 3'd0, 3'd0, 3'd0, 8'd0);
        chk("t3_ill_err", 32'(err), 32'd1);
        chk("t3_ill_code", 32'(err_code), 32'd0);

        // 4: 4-deep instance fills up
        do_start();
        for (int i = 0; i < 3; i++) begin
            hs(3'd5, 3'd0, 3'(i), 3'(i + 1), 8'd0);
            chk("t4_s_wr_en", 32'(s_wr_en), 32'd1);
            chk("t4_s_addr", 32'(s_wr_addr), 32'(i));
            tick();
        end
        hs(3'd5, 3'd0, 3'd1, 3'd2, 8'd0);
        chk("t4_full_err", 32'(s_err), 32'd1);
        chk("t4_full_code", 32'(s_err_code), 32'd3);
        chk("t4_full_no_wr", 32'(s_wr_en), 32'd0);
        chk("t4_full_addr", 32'(s_wr_addr), 32'd3);
        do_start();
        for (int i = 0; i < 3; i++) begin
            hs(3'd5, 3'd0, 3'd1, 3'd2, 8'd0);
            chk("t4b_s_data", 32'(s_wr_data), 32'h1CA);
            tick();
        end
        hs(3'd6, 3'd0, 3'd0, 3'd0, 8'd0);
        chk("t4b_done_wr", 32'(s_wr_en), 32'd1);
        chk("t4b_done_addr", 32'(s_wr_addr), 32'd3);
        chk("t4b_done_data", 32'(s_wr_data), 32'h0FF);
        tick();
        chk("t4b_done_flag", 32'(s_done), 32'd1);
        chk("t4b_prog_len", 32'(s_prog_len), 32'd4);

        // 5: start during WRITE, start beats handshake, async reset mid-WRITE
        do_start();
        hs(3'd5, 3'd0, 3'd1, 3'd2, 8'd0);
        wc = wr_cnt;
        start = 1'b1;
        #1;
        chk("t5_start_drop", 32'(wr_en), 32'd0);
        tick();
        start = 1'b0;
        chk("t5_wr_cnt", 32'(wr_cnt - wc), 32'd0);
        chk("t5_addr0", 32'(wr_addr), 32'd0);
        chk("t5_len0", 32'(prog_len), 32'd0);
        send_chk("t5_after", 3'd2, 3'd0, 3'd1, 3'd0, 8'd0, 8'd0, 9'h148);
        start = 1'b1;
        op_class = 3'd5; reg_a = 3'd1; reg_b = 3'd1; in_valid = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("t5_prio_no_write", 32'(wr_en), 32'd0);
        chk("t5_prio_ready", 32'(in_ready), 32'd1);
        send_chk("t5_s0", 3'd5, 3'd0, 3'd0, 3'd1, 8'd0, 8'd0, 9'h1C1);
        hs(3'd5, 3'd0, 3'd2, 3'd3, 8'd0);
        chk("t5_pre_rst_wr", 32'(wr_en), 32'd1);
        Reset = 1'b1;
        #1;
        chk("t5_rst_wr_en", 32'(wr_en), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_addr", 32'(wr_addr), 32'd0);
        chk("t5_rst_len", 32'(prog_len), 32'd0);
        chk("t5_rst_data", 32'(wr_data), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        tick();

        // 6: in_valid held with changing fields
        do_start();
        wc = wr_cnt;
        in_valid = 1'b1;
        op_class = 3'd5;
        for (int i = 0; i < 6; i++) begin
            reg_a = 3'(i);
            reg_b = 3'(7 - i);
            tick();
            chk("t6_wr_en", 32'(wr_en), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i == 0) chk("t6_d0", 32'(wr_data), 32'h1C7);
            if (i == 2) chk("t6_d2", 32'(wr_data), 32'h1D5);
            if (i == 4) chk("t6_d4", 32'(wr_data), 32'h1E3);
        end
        in_valid = 1'b0;
        tick();
        chk("t6_wr_cnt", 32'(wr_cnt - wc), 32'd3);
        chk("t6_prog_len", 32'(prog_len), 32'd3);
        chk("t6_addr", 32'(wr_addr), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
